// File: rtl/hgcal_quant_pkg.sv
// Shared sizing and types for the HGCAL input quantizer/packer slice.
// Rounding mode of the quantizer is selected with QUANT_ROUND_EN.
package hgcal_quant_pkg;

  localparam int IN_W       = 16;
  localparam int Q_BITS     = 2;
  localparam int SHIFT      = 10;
  localparam int N_FEATURES = 48;

  localparam int CNT_W   = $clog2(N_FEATURES);
  localparam int FRAME_W = N_FEATURES * Q_BITS;

  typedef logic signed [IN_W-1:0] raw_sample_t;
  typedef logic [Q_BITS-1:0]      qcode_t;
  typedef logic [CNT_W-1:0]       cnt_t;
  typedef logic [FRAME_W-1:0]     frame_t;

  localparam qcode_t QMAX = qcode_t'((1 << Q_BITS) - 1);

endpackage

// File: rtl/hgcal_sample_quantizer.sv
// Combinational raw-sample to Q_BITS code: negative clamp, shift, saturate.
// QUANT_ROUND_EN selects round-half-up instead of truncation before saturation.
module hgcal_sample_quantizer
  import hgcal_quant_pkg::*;
(
  input  raw_sample_t sample,
  output qcode_t      code
);

  localparam int EXT_W = IN_W + 1;

  logic [EXT_W-1:0] scaled;

`ifdef QUANT_ROUND_EN
  localparam logic [EXT_W-1:0] HALF_STEP = EXT_W'(1) << (SHIFT - 1);
  // One extra bit keeps 32767 + half-step from wrapping negative.
  assign scaled = ({sample[IN_W-1], sample} + HALF_STEP) >> SHIFT;
`else
  assign scaled = {1'b0, sample} >> SHIFT;
`endif

  assign code = sample[IN_W-1]              ? '0   :
                (scaled > EXT_W'(QMAX))     ? QMAX :
                                              scaled[Q_BITS-1:0];

endmodule

// File: rtl/hgcal_input_quant_packer.sv
// Quantizes a sample stream and packs N_FEATURES codes per frame, double-buffered.
// Build option: QUANT_ROUND_EN (round-half-up quantization inside the quantizer).
module hgcal_input_quant_packer
  import hgcal_quant_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [IN_W-1:0]    s_data,
  input  logic               s_last,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [FRAME_W-1:0] m_data,
  output logic               frame_err
);

  localparam cnt_t LAST_IDX = cnt_t'(N_FEATURES - 1);

  cnt_t   cnt_reg, cnt_next;
  frame_t asm_reg, asm_next, asm_wr;
  frame_t out_reg, out_next;
  logic   asm_full_reg, asm_full_next;
  logic   m_valid_reg, m_valid_next;
  logic   drop_reg, drop_next;
  logic   err_reg, err_next;

  qcode_t code;
  logic   accept, drain, keep, at_last;

  hgcal_sample_quantizer u_quant (
    .sample (s_data),
    .code   (code)
  );

  assign accept  = s_valid & s_ready;
  assign drain   = m_valid_reg & m_ready;
  assign keep    = accept & ~drop_reg;
  assign at_last = (cnt_reg == LAST_IDX);

  // Assembly image with the current sample dropped into its slot.
  for (genvar gi = 0; gi < N_FEATURES; gi++) begin : g_slot
    assign asm_wr[gi*Q_BITS +: Q_BITS] =
      (keep && cnt_reg == cnt_t'(gi)) ? code : asm_reg[gi*Q_BITS +: Q_BITS];
  end

  always_comb begin
    cnt_next      = cnt_reg;
    asm_next      = asm_reg;
    asm_full_next = asm_full_reg;
    out_next      = out_reg;
    m_valid_next  = m_valid_reg;
    drop_next     = drop_reg;
    err_next      = 1'b0;

    if (drain) begin
      m_valid_next = 1'b0;
    end

    // A parked frame follows the draining one with no bubble.
    if (asm_full_reg && drain) begin
      out_next      = asm_reg;
      m_valid_next  = 1'b1;
      asm_full_next = 1'b0;
      asm_next      = '0;
    end

    if (accept) begin
      if (drop_reg) begin
        if (s_last) begin
          drop_next = 1'b0;
        end
      end else if (at_last) begin
        cnt_next = '0;
        asm_next = '0;
        if (s_last) begin
          if (!m_valid_reg || drain) begin
            out_next     = asm_wr;
            m_valid_next = 1'b1;
          end else begin
            asm_next      = asm_wr;
            asm_full_next = 1'b1;
          end
        end else begin
          err_next  = 1'b1;
          drop_next = 1'b1;
        end
      end else if (s_last) begin
        err_next = 1'b1;
        cnt_next = '0;
        asm_next = '0;
      end else begin
        cnt_next = cnt_reg + 1'b1;
        asm_next = asm_wr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg      <= '0;
      asm_reg      <= '0;
      asm_full_reg <= 1'b0;
      out_reg      <= '0;
      m_valid_reg  <= 1'b0;
      drop_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      cnt_reg      <= cnt_next;
      asm_reg      <= asm_next;
      asm_full_reg <= asm_full_next;
      out_reg      <= out_next;
      m_valid_reg  <= m_valid_next;
      drop_reg     <= drop_next;
      err_reg      <= err_next;
    end
  end

  assign s_ready   = ~asm_full_reg;
  assign m_valid   = m_valid_reg;
  assign m_data    = out_reg;
  assign frame_err = err_reg;

endmodule
